idle_monitor: RTL

Multi-channel line-idle detector. Each channel watches an asynchronous, idle-high (or idle-low) serial line such as a PS/2 data or clock pin. A channel declares "asleep" once its line has stayed at the idle level for a runtime-programmable number of cycles. The block emits per-channel level and pulse indications plus aggregate flags, and sits between the raw keyboard/serial pins and the display/power-saving logic.

---
 rtl/idle_monitor.sv | 121 ++++++++++++
 1 files changed

// File: rtl/idle_monitor.sv
// Purpose: per-channel line-idle detector with sleep level/pulse, wake pulse and aggregate flags.
// Latency: pin activity reaches sleep/wake_pulse on the 3rd clock edge; every output is registered.
// Backpressure: none; the block samples every cycle and never stalls.
module idle_monitor #(
  parameter int              N_CH       = 2,
  parameter int              CNT_W      = 27,
  parameter logic [N_CH-1:0] IDLE_LEVEL = {N_CH{1'b1}}
) (
  input  logic             clk_i,
  input  logic             clrn_i,
  input  logic [N_CH-1:0]  ch_in_i,
  input  logic [N_CH-1:0]  ch_en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [N_CH-1:0]  sleep_o,
  output logic [N_CH-1:0]  sleep_pulse_o,
  output logic [N_CH-1:0]  wake_pulse_o,
  output logic             all_asleep_o,
  output logic             any_active_o
);

  typedef enum logic {AWAKE = 1'b0, ASLEEP = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N_CH-1:0]  s1_q, s2_q;
  logic [N_CH-1:0]  act;
  state_t           state_q [N_CH];
  state_t           state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [N_CH-1:0]  sleep_next;
  logic [N_CH-1:0]  sleep_pulse_q, sleep_pulse_d;
  logic [N_CH-1:0]  wake_pulse_q, wake_pulse_d;
  logic             all_asleep_q, all_asleep_d;
  logic             any_active_q, any_active_d;

  // Two-flop synchronizer; resets to the idle level so lines start out idle.
  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      s1_q <= IDLE_LEVEL;
      s2_q <= IDLE_LEVEL;
    end else begin
      s1_q <= ch_in_i;
      s2_q <= s1_q;
    end
  end

  // A synchronized line is active when it differs from its idle polarity.
  assign act = s2_q ^ IDLE_LEVEL;

  // Per-channel next state; disable beats activity, activity beats the timeout.
  always_comb begin
    sleep_pulse_d = '0;
    wake_pulse_d  = '0;
    sleep_next    = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!ch_en_i[i]) begin
        state_d[i] = AWAKE;
        cnt_d[i]   = '0;
      end else if (act[i]) begin
        state_d[i]      = AWAKE;
        cnt_d[i]        = '0;
        wake_pulse_d[i] = (state_q[i] == ASLEEP);
      end else if (state_q[i] == ASLEEP) begin
        // Asleep and idle: counter frozen until the next wake.
        cnt_d[i] = cnt_q[i];
      end else if (cnt_q[i] >= limit_i) begin
        state_d[i]       = ASLEEP;
        sleep_pulse_d[i] = 1'b1;
      end else if (cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      sleep_next[i] = (state_d[i] == ASLEEP);
    end
  end

  // Aggregates are built from the next state so all_asleep lines up with sleep_o.
  always_comb begin
    all_asleep_d = (|ch_en_i) && (&(sleep_next | ~ch_en_i));
    any_active_d = |(act & ch_en_i);
  end

  // Per-channel state, counters, pulses and aggregate registers.
  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= AWAKE;
        cnt_q[i]   <= '0;
      end
      sleep_pulse_q <= '0;
      wake_pulse_q  <= '0;
      all_asleep_q  <= 1'b0;
      any_active_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sleep_pulse_q <= sleep_pulse_d;
      wake_pulse_q  <= wake_pulse_d;
      all_asleep_q  <= all_asleep_d;
      any_active_q  <= any_active_d;
    end
  end

  // Sleep level is the state register itself, packed into a vector.
  always_comb begin
    sleep_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      sleep_o[i] = (state_q[i] == ASLEEP);
    end
  end

  assign sleep_pulse_o = sleep_pulse_q;
  assign wake_pulse_o  = wake_pulse_q;
  assign all_asleep_o  = all_asleep_q;
  assign any_active_o  = any_active_q;

endmodule
